// File: rtl/pipe_stage.sv
// Two-entry skid-buffered pipeline register with registered in_ready, flush,
// bubble-forcing on the control bundle and a saturating back-pressure counter.
module pipe_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stateT;

  stateT             state, stateNext;
  logic [CTRL_W-1:0] mainCtrl, mainCtrlNext, skidCtrl, skidCtrlNext;
  logic [DATA_W-1:0] mainData, mainDataNext, skidData, skidDataNext;
  logic              inReady, inReadyNext;
  logic [CNT_W-1:0]  stallCnt, stallCntNext;
  logic              outValid, push, pop;

  assign outValid  = (state != EMPTY);
  assign push      = in_valid & inReady;
  assign pop       = outValid & out_ready;

  assign in_ready  = inReady;
  assign out_valid = outValid;
  // Control is masked so a drained or flushed stage injects a bubble downstream.
  assign out_ctrl  = outValid ? mainCtrl : '0;
  assign out_data  = mainData;
  // State encoding doubles as the occupancy count.
  assign occ       = state;
  assign stall_cnt = stallCnt;

  always_comb begin
    stateNext    = state;
    mainCtrlNext = mainCtrl;
    mainDataNext = mainData;
    skidCtrlNext = skidCtrl;
    skidDataNext = skidData;
    stallCntNext = stallCnt;

    if (outValid && !out_ready && (stallCnt != '1))
      stallCntNext = stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};

    if (flush) begin
      stateNext = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            stateNext    = ONE;
            mainCtrlNext = in_ctrl;
            mainDataNext = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            mainCtrlNext = in_ctrl;
            mainDataNext = in_data;
          end else if (push) begin
            stateNext    = TWO;
            skidCtrlNext = in_ctrl;
            skidDataNext = in_data;
          end else if (pop) begin
            stateNext = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            stateNext    = ONE;
            mainCtrlNext = skidCtrl;
            mainDataNext = skidData;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end

    inReadyNext = (stateNext != TWO);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      mainCtrl <= '0;
      mainData <= '0;
      skidCtrl <= '0;
      skidData <= '0;
      inReady  <= 1'b1;
      stallCnt <= '0;
    end else begin
      state    <= stateNext;
      mainCtrl <= mainCtrlNext;
      mainData <= mainDataNext;
      skidCtrl <= skidCtrlNext;
      skidData <= skidDataNext;
      inReady  <= inReadyNext;
      stallCnt <= stallCntNext;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed self-checking bench for pipe_stage; a second instance with a
// 2-bit stall counter shares the inputs to exercise saturation.
module tb_pipe_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [11:0] in_ctrl;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [11:0] out_ctrl, out_ctrl2;
  logic [31:0] out_data, out_data2;
  logic [1:0]  occ, occ2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pipe_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .occ(occ),
    .stall_cnt(stall_cnt)
  );

  pipe_stage #(.DATA_W(32), .CTRL_W(12), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .out_ctrl(out_ctrl2), .out_data(out_data2), .occ(occ2),
    .stall_cnt(stall_cnt2)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== 12'h000) begin errors++; $display("FAIL reset_out_ctrl got=%h exp=000", out_ctrl); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occ); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 12'h0A5; in_data = 32'h1234;
    tick();
    in_valid = 1'b0; in_ctrl = 12'hFFF; in_data = 32'hDEAD;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (out_ctrl !== 12'h0A5) begin errors++; $display("FAIL basic_ctrl got=%h exp=0a5", out_ctrl); end
    checks++; if (out_data !== 32'h1234) begin errors++; $display("FAIL basic_data got=%h exp=1234", out_data); end
    checks++; if (occ !== 2'd1) begin errors++; $display("FAIL basic_occ got=%0d exp=1", occ); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== 12'h000) begin errors++; $display("FAIL basic_bubble_ctrl got=%h exp=000", out_ctrl); end
    checks++; if (out_data !== 32'h1234) begin errors++; $display("FAIL basic_hold_data got=%h exp=1234", out_data); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL basic_drain_occ got=%0d exp=0", occ); end
  endtask

  task automatic test_skid();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 12'h011; in_data = 32'hD1D1_0001;
    tick();
    in_ctrl = 12'h022; in_data = 32'hD2D2_0002;
    tick();
    in_valid = 1'b0;
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL skid_occ got=%0d exp=2", occ); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_data !== 32'hD1D1_0001) begin errors++; $display("FAIL skid_head got=%h exp=d1d10001", out_data); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL skid_stall1 got=%0d exp=1", stall_cnt); end
    tick(); tick(); tick();
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL skid_stall4 got=%0d exp=4", stall_cnt); end
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL skid_hold_occ got=%0d exp=2", occ); end
    out_ready = 1'b1;
    checks++; if (out_data !== 32'hD1D1_0001 || out_ctrl !== 12'h011) begin errors++; $display("FAIL skid_pop1 got=%h/%h exp=d1d10001/011", out_data, out_ctrl); end
    tick();
    checks++; if (out_data !== 32'hD2D2_0002 || out_ctrl !== 12'h022) begin errors++; $display("FAIL skid_pop2 got=%h/%h exp=d2d20002/022", out_data, out_ctrl); end
    checks++; if (occ !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL skid_one got occ=%0d rdy=%b exp occ=1 rdy=1", occ, in_ready); end
    tick();
    checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got occ=%0d v=%b exp occ=0 v=0", occ, out_valid); end
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL skid_stall_final got=%0d exp=4", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_ctrl = 12'(i + 1);
      in_data = 32'h100 + 32'(i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h100 + 32'(i) || out_ctrl !== 12'(i + 1))
        begin errors++; $display("FAIL b2b_out[%0d] got v=%b d=%h c=%h exp v=1 d=%h c=%h", i, out_valid, out_data, out_ctrl, 32'h100 + 32'(i), 12'(i + 1)); end
      checks++;
      if (occ !== 2'd1 || in_ready !== 1'b1)
        begin errors++; $display("FAIL b2b_occ[%0d] got occ=%0d rdy=%b exp occ=1 rdy=1", i, occ, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", occ); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 12'h0AA; in_data = 32'hAAAA;
    tick();
    in_ctrl = 12'h0BB; in_data = 32'hBBBB;
    tick();
    flush = 1'b1; in_ctrl = 12'h0CC; in_data = 32'hCCCC;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", occ); end
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 12'h000) begin errors++; $display("FAIL flush_out got v=%b c=%h exp v=0 c=000", out_valid, out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_stall got=%0d exp=2", stall_cnt); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data === 32'hCCCC) begin errors++; $display("FAIL flush_discard got v=%b d=%h exp v=0 d!=cccc", out_valid, out_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 12'h033; in_data = 32'h3333;
    tick();
    in_ctrl = 12'h044; in_data = 32'h4444;
    tick();
    in_valid = 1'b0;
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL areset_pre_occ got=%0d exp=2", occ); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (occ !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL areset_state got occ=%0d v=%b rdy=%b exp 0/0/1", occ, out_valid, in_ready); end
    checks++; if (out_ctrl !== 12'h000 || out_data !== 32'h0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL areset_outs got c=%h d=%h s=%0d exp 0/0/0", out_ctrl, out_data, stall_cnt); end
    #1;
    reset = 1'b0;
    in_valid = 1'b1; in_ctrl = 12'h055; in_data = 32'h5555;
    tick();
    in_valid = 1'b0;
    checks++; if (occ !== 2'd1 || out_data !== 32'h5555) begin errors++; $display("FAIL areset_first got occ=%0d d=%h exp occ=1 d=5555", occ, out_data); end
    tick(); tick(); tick();
    checks++; if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_reach got=%0d exp=3", stall_cnt2); end
    tick(); tick();
    checks++; if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_hold got=%0d exp=3", stall_cnt2); end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL wide_stall got=%0d exp=5", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skid();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
